// File: rtl/apb_pkg.sv
// Shared definitions for the APB command bridge: state encoding,
// default bus widths and the word-alignment mask.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Address bits that must be zero for a word-aligned access.
  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// APB master bridge: takes single read/write commands over valid/ready,
// runs each as an APB SETUP/ACCESS transfer and returns data/status over
// a valid/ready response channel. A wait-state counter aborts transfers
// to a slave that never raises PREADY. Every output comes from a flop.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  // command channel
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  // response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  // APB master port
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pstrb,
  input  logic [DATA_W-1:0]   m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  apb_state_e state_q, state_d;

  // Holding registers: the APB address/data outputs are driven only from these.
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;

  logic              psel_q,    psel_d;
  logic              penable_q, penable_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  logic              rsp_valid_q,   rsp_valid_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;

  logic              misaligned;

  assign misaligned  = (cmd_addr[1:0] & APB_ALIGN_MASK) != 2'b00;
  assign cnt_inc     = cnt_q + 1'b1;
  // Fires on the wait cycle that would bring the count up to TIMEOUT;
  // a PREADY in that same cycle takes priority in the state logic.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // Next-state, holding-register and registered-output logic.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pstrb_d       = pstrb_q;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          // Reads never carry strobes on the bus.
          pstrb_d = cmd_write ? cmd_strb : '0;
          if (misaligned) begin
            // Rejected locally; the slave never sees it.
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d = ST_SETUP;
            psel_d  = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        if (m_pready) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = m_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!write_q && !m_pslverr) ? m_prdata : '0;
        end else if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          cnt_d     = cnt_inc;
        end
      end

      ST_RESP: begin
        // Handshake returns to IDLE; acceptance waits for the next cycle.
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, holding and output registers with asynchronous reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      pstrb_q       <= pstrb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign m_psel      = psel_q;
  assign m_penable   = penable_q;
  assign m_pwrite    = write_q;
  assign m_paddr     = addr_q;
  assign m_pwdata    = wdata_q;
  assign m_pstrb     = pstrb_q;

endmodule
